bus_transfer_sequencer: RTL and testbench

Drives the encoded datapath bus from the control side. It takes register-to-register transfer requests as 5-bit source and destination codes. It decodes the source code into the 32-bit one-hot drive-select word that feeds the bus encoder/mux. It decodes the destination code into a one-hot load-enable word, and sequences drive, settle, load and done over a valid/ready handshake.

---
 rtl/bus_transfer_sequencer.sv | 130 +++++++++++++
 tb/tb_bus_transfer_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_transfer_sequencer.sv
// bus_transfer_sequencer: decodes 5-bit source/destination codes into one-hot bus drive and load
// strobes, sequencing drive, settle, load and done over a valid/ready handshake.
module bus_transfer_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       src_code,
    input  logic [4:0]       dst_code,
    output logic [31:0]      drive_sel,
    output logic [31:0]      load_en,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] xfer_count
);
    typedef enum logic [1:0] {IDLE, DRIVE, LOAD, DONE} state_t;

    // Bus-loadable destinations: R0-R15, HI, LO, PC, MDR, MAR, Y
    localparam logic [31:0] DST_OK = 32'h0333_FFFF;
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t state_q, state_d;
    logic [4:0] src_q, src_d, dst_q, dst_d;
    logic [3:0] cnt_q, cnt_d;
    logic flag_q, flag_d;
    logic [31:0] drive_q, drive_d, load_q, load_d;
    logic busy_q, busy_d, done_q, done_d, err_q, err_d, ready_q, ready_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic req_ok;

    assign req_ok = (src_code < 5'd24) && DST_OK[dst_code];

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        drive_d = '0;
        load_d  = '0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        err_d   = 1'b0;
        ready_d = 1'b0;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                busy_d  = req_valid;
                ready_d = !req_valid;
                if (req_valid) begin
                    src_d  = src_code;
                    dst_d  = dst_code;
                    flag_d = !req_ok;
                    if (req_ok) begin
                        state_d = DRIVE;
                        cnt_d   = CNT_INIT;
                        drive_d = 32'd1 << src_code;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            DRIVE: begin
                drive_d = 32'd1 << src_q;
                if (cnt_q == 4'd0) begin
                    state_d = LOAD;
                    load_d  = 32'd1 << dst_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            LOAD: begin
                state_d = DONE;
                done_d  = 1'b1;
                err_d   = flag_q;
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b1;
                count_d = flag_q ? count_q : count_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            drive_q <= '0;
            load_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            drive_q <= drive_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            count_q <= count_d;
        end
    end

    assign req_ready  = ready_q;
    assign drive_sel  = drive_q;
    assign load_en    = load_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign xfer_count = count_q;
endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// tb_bus_transfer_sequencer: two sequencers (settle 1 / 16-bit count, settle 3 / 2-bit count) on
// shared inputs, compared each cycle against a transaction-timeline reference model.
module tb_bus_transfer_sequencer;
    logic clk = 1'b0;
    logic clear, req_valid;
    logic [4:0] src_code, dst_code;
    logic rdy1, busy1, done1, err1, rdy3, busy3, done3, err3;
    logic [31:0] drv1, ld1, drv3, ld3;
    logic [15:0] cnt1;
    logic [1:0] cnt3;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_transfer_sequencer #(.SETTLE_CYCLES(1), .CNT_W(16)) u1 (
        .clk(clk), .clear(clear), .req_valid(req_valid), .req_ready(rdy1),
        .src_code(src_code), .dst_code(dst_code), .drive_sel(drv1), .load_en(ld1),
        .busy(busy1), .done(done1), .err(err1), .xfer_count(cnt1));

    bus_transfer_sequencer #(.SETTLE_CYCLES(3), .CNT_W(2)) u3 (
        .clk(clk), .clear(clear), .req_valid(req_valid), .req_ready(rdy3),
        .src_code(src_code), .dst_code(dst_code), .drive_sel(drv3), .load_en(ld3),
        .busy(busy3), .done(done3), .err(err3), .xfer_count(cnt3));

    typedef struct packed {
        logic [31:0] drv;
        logic [31:0] ld;
        logic busy, done, err, ready;
        logic [15:0] cnt;
    } obs_t;

    function automatic int sv(int i);
        return i == 0 ? 1 : 3;
    endfunction

    function automatic int wmask(int i);
        return i == 0 ? 32'hFFFF : 3;
    endfunction

    function automatic bit legal(logic [4:0] s, logic [4:0] d);
        return (s < 5'd24) && (d inside {[5'd0:5'd17], 5'd20, 5'd21, 5'd24, 5'd25});
    endfunction

    // Model: each accepted request is remembered with its acceptance edge; outputs follow from the
    // cycle offset since that edge.
    int ecnt = 0;
    int acc[2] = '{0, 0};
    int dcnt[2] = '{0, 0};
    bit act[2] = '{0, 0};
    bit lgl[2] = '{0, 0};
    logic [4:0] msrc[2], mdst[2];

    always @(posedge clk) begin
        ecnt <= ecnt + 1;
        for (int i = 0; i < 2; i++) begin
            if (clear) begin
                act[i] <= 1'b0;
                dcnt[i] <= 0;
            end else if (!act[i] || (ecnt + 1 - acc[i]) >= (lgl[i] ? sv(i) + 3 : 2)) begin
                if (act[i] && lgl[i]) dcnt[i] <= dcnt[i] + 1;
                act[i] <= req_valid;
                acc[i] <= ecnt + 1;
                msrc[i] <= src_code;
                mdst[i] <= dst_code;
                lgl[i] <= legal(src_code, dst_code);
            end
        end
    end

    function automatic obs_t expv(int i);
        obs_t o;
        int off, s;
        o = '0;
        o.ready = 1'b1;
        s = sv(i);
        off = ecnt - acc[i] + 1;
        if (act[i]) begin
            if (lgl[i]) begin
                o.drv = (off <= s + 1) ? (32'd1 << msrc[i]) : 32'd0;
                o.ld = (off == s + 1) ? (32'd1 << mdst[i]) : 32'd0;
                o.done = (off == s + 2);
                o.busy = (off <= s + 2);
                o.ready = (off >= s + 3);
            end else begin
                o.done = (off == 1);
                o.err = (off == 1);
                o.busy = (off == 1);
                o.ready = (off >= 2);
            end
        end
        o.cnt = 16'((dcnt[i] + ((act[i] && lgl[i] && off >= s + 3) ? 1 : 0)) & wmask(i));
        return o;
    endfunction

    function automatic obs_t got(int i);
        obs_t o;
        if (i == 0) o = {drv1, ld1, busy1, done1, err1, rdy1, cnt1};
        else o = {drv3, ld3, busy3, done3, err3, rdy3, 14'd0, cnt3};
        return o;
    endfunction

    task automatic step(bit v, logic [4:0] s, logic [4:0] d, bit c);
        req_valid = v;
        src_code = s;
        dst_code = d;
        clear = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (!(rdy1 && rdy3) && n < 40) begin
            step(0, 5'd0, 5'd0, 0);
            n++;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL drain dut%0d t=%0t got %h exp %h", i, $time, got(i), expv(i));
                end
            end
        end
        checks++;
        if (!(rdy1 && rdy3)) begin
            errors++;
            $display("FAIL drain_timeout ready got %b%b exp 11", rdy1, rdy3);
        end
    endtask

    task automatic test_reset();
        step(1, 5'd3, 5'd4, 1);
        step(1, 5'd3, 5'd4, 1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got(i) !== expv(i)) begin
                errors++;
                $display("FAIL reset dut%0d got %h exp %h", i, got(i), expv(i));
            end
        end
        checks++;
        if ({rdy1, busy1, done1, err1, cnt1, drv1, ld1} !== {4'b1000, 16'd0, 64'd0}) begin
            errors++;
            $display("FAIL reset_const got %h exp %h", {rdy1, busy1, done1, err1, cnt1, drv1, ld1},
                     {4'b1000, 16'd0, 64'd0});
        end
    endtask

    task automatic test_r0_r5();
        logic [65:0] want;
        step(1, 5'd0, 5'd5, 0);
        for (int j = 1; j <= 4; j++) begin
            if (j > 1) step(0, 5'd9, 5'd9, 0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL r0_r5 dut%0d cyc%0d got %h exp %h", i, j, got(i), expv(i));
                end
            end
            want = j == 1 ? {32'h1, 32'h0, 2'b00} : j == 2 ? {32'h1, 32'h20, 2'b00} :
                   j == 3 ? {64'h0, 2'b10} : {64'h0, 2'b01};
            checks++;
            if ({drv1, ld1, done1, rdy1} !== want) begin
                errors++;
                $display("FAIL r0_r5_const cyc%0d got %h exp %h", j, {drv1, ld1, done1, rdy1}, want);
            end
        end
        checks++;
        if (cnt1 !== 16'd1) begin
            errors++;
            $display("FAIL r0_r5_count got %0d exp 1", cnt1);
        end
        drain();
    endtask

    task automatic test_mdr_pc();
        step(1, 5'd21, 5'd20, 0);
        for (int j = 1; j <= 5; j++) begin
            if (j > 1) step(0, 5'd1, 5'd2, 0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL mdr_pc dut%0d cyc%0d got %h exp %h", i, j, got(i), expv(i));
                end
            end
            checks++;
            if ({drv3, ld3} !== {(j <= 4 ? 32'h0020_0000 : 32'h0), (j == 4 ? 32'h0010_0000 : 32'h0)}) begin
                errors++;
                $display("FAIL mdr_pc_const cyc%0d got %h_%h", j, drv3, ld3);
            end
        end
        drain();
    endtask

    task automatic test_illegal();
        logic [9:0] codes[2] = '{{5'd24, 5'd1}, {5'd3, 5'd18}};
        logic [15:0] c1;
        logic [1:0] c3;
        for (int k = 0; k < 2; k++) begin
            c1 = cnt1;
            c3 = cnt3;
            step(1, codes[k][9:5], codes[k][4:0], 0);
            checks++;
            if ({done1, err1, done3, err3, drv1, ld1, drv3, ld3, cnt1, cnt3} !== {4'hF, 128'd0, c1, c3}) begin
                errors++;
                $display("FAIL illegal%0d got %b%b%b%b %h %h/%h", k, done1, err1, done3, err3,
                         {drv1, ld1, drv3, ld3}, cnt1, cnt3);
            end
            step(0, 5'd0, 5'd0, 0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL illegal_after dut%0d got %h exp %h", i, got(i), expv(i));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 40; j++) begin
            step(1, 5'($urandom_range(0, 25)), 5'($urandom_range(0, 25)), 0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL back_to_back dut%0d cyc%0d got %h exp %h", i, j, got(i), expv(i));
                end
            end
        end
        drain();
    endtask

    task automatic test_clear_mid_load();
        step(1, 5'd7, 5'd9, 0);
        step(0, 5'd1, 5'd1, 0);
        checks++;
        if (ld1 !== 32'h0000_0200) begin
            errors++;
            $display("FAIL load_cycle got %h exp 00000200", ld1);
        end
        step(0, 5'd1, 5'd1, 1);
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL clear_mid_load dut%0d cyc%0d got %h exp %h", i, j, got(i), expv(i));
                end
            end
            checks++;
            if ({ld1, ld3, done1, done3, busy1, rdy1} !== {64'd0, 4'b0001}) begin
                errors++;
                $display("FAIL clear_mid_load_const cyc%0d got %h_%h %b%b%b%b", j, ld1, ld3, done1, done3, busy1, rdy1);
            end
            step(0, 5'd0, 5'd0, 0);
        end
    endtask

    task automatic test_wrap();
        step(0, 5'd0, 5'd0, 1);
        for (int n = 1; n <= 4; n++) begin
            step(1, 5'(n), 5'(n + 1), 0);
            drain();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL wrap dut%0d n%0d got %h exp %h", i, n, got(i), expv(i));
                end
            end
            checks++;
            if ({cnt1, cnt3} !== {16'(n), 2'(n)}) begin
                errors++;
                $display("FAIL wrap_count n%0d got %0d/%0d exp %0d/%0d", n, cnt1, cnt3, n, n % 4);
            end
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 400; j++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), $urandom_range(0, 49) == 0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got(i) !== expv(i)) begin
                    errors++;
                    $display("FAIL random dut%0d cyc%0d got %h exp %h", i, j, got(i), expv(i));
                end
            end
        end
    endtask

    initial begin
        clear = 1'b1;
        req_valid = 1'b0;
        src_code = '0;
        dst_code = '0;
        test_reset();
        test_r0_r5();
        test_mdr_pc();
        test_illegal();
        test_back_to_back();
        test_clear_mid_load();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
